// File: rtl/ov7670_pkg.sv
// Shared definitions for the OV7670 configuration sequencer:
// ROM control tokens, sequencer state encoding and common sensor register addresses.
package ov7670_pkg;

    localparam logic [15:0] TOK_END   = 16'hFFFF;
    localparam logic [15:0] TOK_DELAY = 16'hFFF0;

    localparam logic [7:0] CLKRC = 8'h11;
    localparam logic [7:0] COM7  = 8'h12;
    localparam logic [7:0] COM10 = 8'h15;
    localparam logic [7:0] TSLB  = 8'h3A;
    localparam logic [7:0] COM15 = 8'h40;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        DECODE,
        WRITE,
        WAIT_ACK,
        DELAY,
        ADVANCE,
        DONE,
        ERROR
    } state_t;

    function automatic logic is_token(input logic [15:0] word);
        return (word == TOK_END) || (word == TOK_DELAY);
    endfunction

endpackage

// File: rtl/ov7670_cfg_sequencer_delay_timer.sv
// Loadable down-counter for ROM delay tokens. A load sets the count to
// DELAY_CYCLES-1; while enabled it counts down and stops at zero.
module cfg_delay_timer
    import ov7670_pkg::*;
#(
    parameter int DELAY_CYCLES = 240000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic zero
);

    localparam int CNT_W = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(DELAY_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // Count register: load has priority, then decrement until zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (en && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/ov7670_cfg_sequencer.sv
// OV7670 configuration sequencer: walks the external config ROM for the
// selected profile and issues one SCCB write per {reg, value} word.
// Optional build macro SEQ_RETRY_EN: retry NACKed writes up to MAX_RETRY
// times before flagging an error; without it a NACK counts as an ACK.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start after reset
// FETCH    | rom_addr presented, ROM read in flight
// DECODE   | examine ROM word: end token, delay token or register write
// WRITE    | wr_valid held until the SCCB master accepts
// WAIT_ACK | waiting for wr_done from the bus transaction
// DELAY    | timing out a delay token
// ADVANCE  | step to the next entry, or flag a table overrun
// DONE     | table finished cleanly, waiting for a new start
// ERROR    | overrun or retries exhausted, waiting for a new start
module ov7670_cfg_sequencer
    import ov7670_pkg::*;
#(
    parameter int IDX_W        = 8,
    parameter int MODE_W       = 2,
    parameter int DELAY_CYCLES = 240000,
    parameter int MAX_RETRY    = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [MODE_W-1:0]       mode,
    output logic [MODE_W+IDX_W-1:0] rom_addr,
    input  logic [15:0]             rom_data,
    output logic                    wr_valid,
    input  logic                    wr_ready,
    output logic [7:0]              wr_reg,
    output logic [7:0]              wr_data,
    input  logic                    wr_done,
    input  logic                    wr_nack,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [IDX_W:0]          wr_count
);

    localparam logic [IDX_W-1:0] IDX_LAST = '1;

    state_t            state;
    state_t            state_n;
    logic [MODE_W-1:0] mode_q;
    logic [IDX_W-1:0]  idx;
    logic              run_init;
    logic              latch_wr;
    logic              idx_inc;
    logic              cnt_inc;
    logic              timer_load;
    logic              timer_zero;

`ifdef SEQ_RETRY_EN
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [RETRY_W-1:0] retry_cnt;
    logic               retry_inc;
    logic               retry_clr;
`else
    // NACK status and retry limit have no effect in the fire-and-forget build.
    logic unused_cfg;
    assign unused_cfg = wr_nack ^ MAX_RETRY[0];
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic and datapath strobes.
    always_comb begin
        state_n    = state;
        run_init   = 1'b0;
        latch_wr   = 1'b0;
        idx_inc    = 1'b0;
        cnt_inc    = 1'b0;
        timer_load = 1'b0;
`ifdef SEQ_RETRY_EN
        retry_inc  = 1'b0;
        retry_clr  = 1'b0;
`endif
        unique case (state)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    run_init = 1'b1;
                    state_n  = FETCH;
                end
            end
            FETCH: state_n = DECODE;
            DECODE: begin
                if (rom_data == TOK_END) begin
                    state_n = DONE;
                end else if (rom_data == TOK_DELAY) begin
                    timer_load = 1'b1;
                    state_n    = DELAY;
                end else begin
                    latch_wr = 1'b1;
                    state_n  = WRITE;
                end
            end
            WRITE: begin
                if (wr_ready) begin
                    state_n = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (wr_done) begin
`ifdef SEQ_RETRY_EN
                    if (wr_nack) begin
                        if (retry_cnt == RETRY_W'(MAX_RETRY)) begin
                            state_n = ERROR;
                        end else begin
                            retry_inc = 1'b1;
                            state_n   = WRITE;
                        end
                    end else begin
                        cnt_inc   = 1'b1;
                        retry_clr = 1'b1;
                        state_n   = ADVANCE;
                    end
`else
                    cnt_inc = 1'b1;
                    state_n = ADVANCE;
`endif
                end
            end
            DELAY: begin
                if (timer_zero) begin
                    state_n = ADVANCE;
                end
            end
            ADVANCE: begin
                if (idx == IDX_LAST) begin
                    state_n = ERROR;
                end else begin
                    idx_inc = 1'b1;
                    state_n = FETCH;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Run context: profile, table index, latched write word and write count.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= '0;
            idx      <= '0;
            wr_reg   <= '0;
            wr_data  <= '0;
            wr_count <= '0;
        end else begin
            if (run_init) begin
                mode_q   <= mode;
                idx      <= '0;
                wr_count <= '0;
            end
            if (idx_inc) begin
                idx <= idx + IDX_W'(1);
            end
            if (latch_wr) begin
                wr_reg  <= rom_data[15:8];
                wr_data <= rom_data[7:0];
            end
            if (cnt_inc) begin
                wr_count <= wr_count + (IDX_W+1)'(1);
            end
        end
    end

`ifdef SEQ_RETRY_EN
    // Consecutive NACKs on the current entry; cleared by an ACK or a new run.
    always_ff @(posedge clk) begin
        if (rst) begin
            retry_cnt <= '0;
        end else if (run_init || retry_clr) begin
            retry_cnt <= '0;
        end else if (retry_inc) begin
            retry_cnt <= retry_cnt + RETRY_W'(1);
        end
    end
`endif

    cfg_delay_timer #(
        .DELAY_CYCLES(DELAY_CYCLES)
    ) u_delay_timer (
        .clk  (clk),
        .rst  (rst),
        .load (timer_load),
        .en   (state == DELAY),
        .zero (timer_zero)
    );

    assign rom_addr = {mode_q, idx};
    assign wr_valid = (state == WRITE);
    assign busy     = !((state == IDLE) || (state == DONE) || (state == ERROR));
    assign done     = (state == DONE);
    assign error    = (state == ERROR);

endmodule

// File: tb/tb_ov7670_cfg_sequencer.sv
// Directed bench for ov7670_cfg_sequencer: registered ROM model and a
// simple SCCB master model with configurable stall, ACK delay and NACKs.
module tb_ov7670_cfg_sequencer;
    import ov7670_pkg::*;

    localparam int IDX_W        = 8;
    localparam int MODE_W       = 2;
    localparam int DELAY_CYCLES = 16;
    localparam int MAX_RETRY    = 3;
    localparam int AW           = MODE_W + IDX_W;
    localparam int ACK_DLY      = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [MODE_W-1:0] mode = '0;
    logic [AW-1:0]     rom_addr;
    logic [15:0]       rom_data;
    logic              wr_valid;
    logic              wr_ready = 1'b1;
    logic [7:0]        wr_reg;
    logic [7:0]        wr_data;
    logic              wr_done = 1'b0;
    logic              wr_nack = 1'b0;
    logic              busy;
    logic              done;
    logic              error;
    logic [IDX_W:0]    wr_count;

    logic [15:0] rom [0:(1<<AW)-1];

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    int   ack_cnt, nack_left, stall_left, stall_seen, addr_hi;
    bit   stall_bad, prev_valid, inj_done;
    logic [7:0] st_reg, st_data;
    int   vcyc[$];
    int   done_cyc[$];
    int   wlog[$];

    ov7670_cfg_sequencer #(
        .IDX_W(IDX_W), .MODE_W(MODE_W), .DELAY_CYCLES(DELAY_CYCLES), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .rom_addr(rom_addr),
        .rom_data(rom_data), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_reg(wr_reg),
        .wr_data(wr_data), .wr_done(wr_done), .wr_nack(wr_nack), .busy(busy),
        .done(done), .error(error), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    // SCCB master model, evaluated once per cycle just after the falling edge.
    task automatic model_step();
        if (wr_valid && !prev_valid) vcyc.push_back(cyc);
        prev_valid = wr_valid;
        wr_done = 1'b0;
        wr_nack = 1'b0;
        if (inj_done) begin
            wr_done  = 1'b1;
            inj_done = 1'b0;
        end
        if (ack_cnt > 0) begin
            ack_cnt--;
            if (ack_cnt == 0) begin
                wr_done = 1'b1;
                wr_nack = (nack_left > 0);
                if (nack_left > 0) nack_left--;
                done_cyc.push_back(cyc);
            end
        end
        if (wr_valid && stall_left > 0) begin
            wr_ready = 1'b0;
            if (stall_seen == 0) begin
                st_reg  = wr_reg;
                st_data = wr_data;
                addr_hi = int'(rom_addr[AW-1:IDX_W]);
            end else if (wr_reg !== st_reg || wr_data !== st_data) begin
                stall_bad = 1'b1;
            end
            stall_seen++;
            stall_left--;
        end else begin
            wr_ready = 1'b1;
        end
        if (wr_valid && wr_ready) begin
            wlog.push_back(int'({wr_reg, wr_data}));
            ack_cnt = ACK_DLY;
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_step();
    endtask

    task automatic clear_log();
        vcyc.delete();
        done_cyc.delete();
        wlog.delete();
        ack_cnt    = 0;
        nack_left  = 0;
        stall_left = 0;
        stall_seen = 0;
        stall_bad  = 1'b0;
        inj_done   = 1'b0;
        addr_hi    = -1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < (1 << AW); i++) rom[i] = TOK_END;
    endtask

    task automatic run(input int m, output int s);
        mode  = m[MODE_W-1:0];
        start = 1'b1;
        s     = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic wait_end(input int budget, input string tag);
        int n = 0;
        while (busy && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_finished"}, int'(busy), 0);
    endtask

    initial begin
        int s;
        int n;
        clear_rom();
        clear_log();

        // Reset values
        rst = 1'b1;
        step();
        step();
        chk("rst_valid", int'(wr_valid), 0);
        chk("rst_busy",  int'(busy), 0);
        chk("rst_flags", int'({done, error}), 0);
        chk("rst_addr",  int'(rom_addr), 0);
        chk("rst_wr",    int'({wr_reg, wr_data}), 0);
        chk("rst_count", int'(wr_count), 0);
        rst = 1'b0;
        step();

        // Two writes then end token
        rom[0] = {COM7, 8'h80};
        rom[1] = {CLKRC, 8'h01};
        clear_log();
        run(0, s);
        wait_end(200, "t1");
        chk("t1_nwr",   wlog.size(), 2);
        chk("t1_w0",    qget(wlog, 0), 16'h1280);
        chk("t1_w1",    qget(wlog, 1), 16'h1101);
        chk("t1_lat",   qget(vcyc, 0) - s, 3);
        chk("t1_gap",   qget(vcyc, 1) - qget(done_cyc, 0), 4);
        chk("t1_done",  int'(done), 1);
        chk("t1_error", int'(error), 0);
        chk("t1_count", int'(wr_count), 2);

        // Delay token: ADVANCE, FETCH, DECODE, DELAY_CYCLES, ADVANCE, FETCH, DECODE
        clear_rom();
        rom[0] = 16'h1280;
        rom[1] = TOK_DELAY;
        rom[2] = 16'h1200;
        clear_log();
        run(0, s);
        wait_end(300, "t2");
        chk("t2_nwr",  wlog.size(), 2);
        chk("t2_w1",   qget(wlog, 1), 16'h1200);
        chk("t2_gap",  qget(vcyc, 1) - qget(done_cyc, 0), DELAY_CYCLES + 7);
        chk("t2_done", int'(done), 1);

        // Profile 2 with the master stalling for 10 cycles
        clear_rom();
        rom[10'h200] = {COM10, 8'h04};
        clear_log();
        stall_left = 10;
        run(2, s);
        wait_end(200, "t3");
        chk("t3_addr_hi", addr_hi, 2);
        chk("t3_stall",   stall_seen, 10);
        chk("t3_stable",  int'(stall_bad), 0);
        chk("t3_nwr",     wlog.size(), 1);
        chk("t3_w0",      qget(wlog, 0), 16'h1504);
        chk("t3_done",    int'(done), 1);

        // One NACK on the first entry
        clear_rom();
        rom[0] = 16'h1280;
        rom[1] = 16'h1101;
        clear_log();
        nack_left = 1;
        run(0, s);
        wait_end(300, "t4");
`ifdef SEQ_RETRY_EN
        chk("t4_nwr",  wlog.size(), 3);
        chk("t4_w1",   qget(wlog, 1), 16'h1280);
        chk("t4_w2",   qget(wlog, 2), 16'h1101);
`else
        chk("t4_nwr",  wlog.size(), 2);
        chk("t4_w1",   qget(wlog, 1), 16'h1101);
`endif
        chk("t4_count", int'(wr_count), 2);
        chk("t4_done",  int'(done), 1);

        // Four NACKs on the first entry
        clear_log();
        nack_left = 4;
        run(0, s);
        wait_end(300, "t4b");
`ifdef SEQ_RETRY_EN
        chk("t4b_error", int'(error), 1);
        chk("t4b_done",  int'(done), 0);
        chk("t4b_addr",  int'(rom_addr), 0);
        chk("t4b_nwr",   wlog.size(), 4);
        chk("t4b_count", int'(wr_count), 0);
`else
        chk("t4b_error", int'(error), 0);
        chk("t4b_done",  int'(done), 1);
        chk("t4b_nwr",   wlog.size(), 2);
        chk("t4b_count", int'(wr_count), 2);
`endif

        // Full profile with no end token: overrun after 256 writes
        clear_rom();
        for (int i = 0; i < 256; i++) rom[256 + i] = {COM15, i[7:0]};
        clear_log();
        run(1, s);
        wait_end(6000, "t5");
        chk("t5_error", int'(error), 1);
        chk("t5_done",  int'(done), 0);
        chk("t5_count", int'(wr_count), 256);
        chk("t5_nwr",   wlog.size(), 256);
        chk("t5_last",  qget(wlog, 255), 16'h40FF);
        chk("t5_addr",  int'(rom_addr), 10'h1FF);

        // Reset while stuck in WRITE
        clear_rom();
        rom[0] = 16'h1280;
        clear_log();
        stall_left = 50;
        run(0, s);
        step();
        step();
        step();
        chk("t6_in_write", int'(wr_valid), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_valid", int'(wr_valid), 0);
        chk("t6_busy",  int'(busy), 0);
        chk("t6_wr",    int'({wr_reg, wr_data}), 0);
        chk("t6_addr",  int'(rom_addr), 0);

        // Reset while in DELAY, then a stray wr_done
        rom[0] = 16'h1280;
        rom[1] = TOK_DELAY;
        rom[2] = 16'h1101;
        clear_log();
        run(0, s);
        n = 0;
        while (done_cyc.size() == 0 && n < 50) begin
            step();
            n++;
        end
        chk("t7_ack_seen", done_cyc.size(), 1);
        for (int i = 0; i < 6; i++) step();
        chk("t7_in_delay", int'({busy, wr_valid}), 2'b10);
        chk("t7_count_pre", int'(wr_count), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t7_busy",  int'(busy), 0);
        chk("t7_count", int'(wr_count), 0);
        chk("t7_flags", int'({done, error}), 0);
        inj_done = 1'b1;
        step();
        step();
        chk("t7_stray_busy",  int'(busy), 0);
        chk("t7_stray_count", int'(wr_count), 0);

        // Fresh run after reset starts again from entry 0
        clear_log();
        run(0, s);
        wait_end(300, "t8");
        chk("t8_nwr",   wlog.size(), 2);
        chk("t8_w0",    qget(wlog, 0), 16'h1280);
        chk("t8_w1",    qget(wlog, 1), 16'h1101);
        chk("t8_done",  int'(done), 1);
        chk("t8_count", int'(wr_count), 2);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
